count_pwm_gen: RTL
==================

COUNT_PWM_GEN -- requirements
Module: count_pwm_gen

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 255, terminal value of the upstream param_counter; W = $clog2(MAX_COUNT+1).
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port count  input  W  free-running count from upstream param_counter, sampled each clk.
REQ-005 SHALL have port duty_in  input  W  requested duty (high-cycles per period).
REQ-006 SHALL have port duty_valid  input  1  duty_in valid.
REQ-007 SHALL have port duty_ready  output  1  shadow register free; transfer when duty_valid && duty_ready.
REQ-008 SHALL have port pwm_out  output  1  registered PWM output.
REQ-009 SHALL have port wrap_pulse  output  1  one-cycle pulse per detected counter wrap.
REQ-010 SHALL have port duty_active  output  W  duty applied to the current period.

Function
REQ-011 SHALL register count into prev_count every cycle.
REQ-012 SHALL detect wrap when prev_count == MAX_COUNT and count == 0.
REQ-013 SHALL detect resync when count == 0, prev_count != MAX_COUNT and prev_count != 0 (upstream reset mid-period).
REQ-014 SHALL implement FSM SYNC/RUN: SYNC -> RUN on wrap; RUN -> SYNC on resync; wrap has priority (mutually exclusive by definition).
REQ-015 SHALL hold pwm_out low in SYNC; in RUN set pwm_out <= (count < duty_eff), one-cycle latency from count.
REQ-016 SHALL define duty_eff = shadow value on a wrap cycle with pending set, else duty_active, so a new duty takes effect on the first sample of the new period.
REQ-017 SHALL saturate accepted duty_in values above MAX_COUNT to MAX_COUNT; duty 0 -> pwm_out always low; duty MAX_COUNT -> low only for count == MAX_COUNT.
REQ-018 SHALL keep pending flag; duty_ready = !pending; accepted transfer loads shadow and sets pending.
REQ-019 SHALL on wrap with pending set copy shadow to duty_active and clear pending on the same edge; duty_ready rises the next cycle.
REQ-020 SHALL, when a transfer coincides with a wrap while pending is clear, load shadow only; it applies at the following wrap.
REQ-021 SHALL assert wrap_pulse for exactly one cycle, the cycle after count == 0 was sampled on a wrap, in both SYNC and RUN.
REQ-022 SHALL on resync keep shadow, pending and duty_active unchanged.

Reset
REQ-023 SHALL on rst asynchronously set: FSM SYNC, prev_count 0, pending 0, shadow 0, duty_active 0, pwm_out 0, wrap_pulse 0; duty_ready reads 1.
REQ-024 SHALL resume on the first rising clk edge after rst deasserts, with no handshake lost or duplicated.

Configuration
REQ-025 SHALL, with macro PWM_PERIOD_CNT_EN defined, add output period_cnt[15:0] incrementing on each wrap_pulse, saturating at 16'hFFFF, reset to 0, cleared on resync.
REQ-026 SHALL, without PWM_PERIOD_CNT_EN, omit the period_cnt port and its logic; all other behaviour identical.

Verification
REQ-027 SHALL cover (MAX_COUNT=9): reset, count 0..9 repeating, no duty write -> pwm_out low throughout, wrap_pulse once per 10 cycles, duty_active 0.
REQ-028 SHALL cover: duty_in=3 accepted mid-period -> duty_ready low until wrap; from next period pwm_out high for count 0,1,2, low for 3..9; duty_active=3 after wrap.
REQ-029 SHALL cover: duty_in=15 (>9) -> saturated to 9, pwm_out low only at count 9; duty_in=0 -> pwm_out constantly low.
REQ-030 SHALL cover: transfer duty 5 on the wrap cycle with pending clear -> applies one period later; second valid while pending -> stalled (ready low), accepted after wrap.
REQ-031 SHALL cover: count jumps 6 -> 0 (upstream reset) -> FSM SYNC, pwm_out low, no wrap_pulse until next 9 -> 0; duty_active retained.
REQ-032 SHALL cover: rst asserted mid-period with pending set -> all outputs reset immediately; with PWM_PERIOD_CNT_EN, period_cnt returns to 0 and counts 1,2,3 over three wraps.

Source files
------------

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: PWM generator slaved to an external free-running counter.
//   Samples the upstream param_counter value, detects period wraps and
//   mid-period upstream resets, and drives a registered PWM output whose duty
//   is changed only at period boundaries through a valid/ready shadow register.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   count        upstream counter value, 0..MAX_COUNT
//   duty_in      requested duty (high cycles per period), saturated to MAX_COUNT
//   duty_valid   duty_in valid
//   duty_ready   shadow register free (transfer on duty_valid && duty_ready)
//   pwm_out      registered PWM output
//   wrap_pulse   one-cycle pulse per detected counter wrap
//   duty_active  duty applied to the current period
//   period_cnt   (only with PWM_PERIOD_CNT_EN) saturating count of wraps
//
// Optional feature macro: PWM_PERIOD_CNT_EN adds the period_cnt output.
module count_pwm_gen #(
  parameter int unsigned MAX_COUNT = 255,
  localparam int unsigned W = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] count,
  input  logic [W-1:0] duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         pwm_out,
  output logic         wrap_pulse,
  output logic [W-1:0] duty_active
`ifdef PWM_PERIOD_CNT_EN
  ,
  output logic [15:0]  period_cnt
`endif
);

  localparam logic [W-1:0] MAX_VAL = W'(MAX_COUNT);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] prev_count;
  logic [W-1:0] shadow_q;
  logic [W-1:0] shadow_d;
  logic         pending_q;
  logic         pending_d;
  logic [W-1:0] active_d;
  logic         pwm_d;
  logic         wrap_c;
  logic         resync_c;
  logic [W-1:0] duty_sat_c;
  logic [W-1:0] duty_eff_c;

  // Period boundary detection from consecutive samples.
  assign wrap_c   = (prev_count == MAX_VAL) && (count == '0);
  assign resync_c = (count == '0) && (prev_count != MAX_VAL) && (prev_count != '0);

  assign duty_sat_c = (duty_in > MAX_VAL) ? MAX_VAL : duty_in;

  // A pending duty is used for the very first sample of the new period.
  assign duty_eff_c = (wrap_c && pending_q) ? shadow_q : duty_active;

  // Next-state and PWM decision; output follows the state being entered so a
  // resync silences pwm_out immediately and a wrap drives the first sample.
  always_comb begin
    state_d = state_q;
    pwm_d   = 1'b0;
    case (state_q)
      SYNC:    if (wrap_c)   state_d = RUN;
      RUN:     if (resync_c) state_d = SYNC;
      default: state_d = SYNC;
    endcase
    if (state_d == RUN) pwm_d = (count < duty_eff_c);
  end

  // Shadow/pending handshake; wrap commit and transfer are exclusive on pending.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = duty_active;
    if (wrap_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (duty_valid && !pending_q) begin
      shadow_d  = duty_sat_c;
      pending_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SYNC;
      prev_count  <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      duty_ready  <= 1'b1;
      duty_active <= '0;
      pwm_out     <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_count  <= count;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      duty_ready  <= !pending_d;
      duty_active <= active_d;
      pwm_out     <= pwm_d;
      wrap_pulse  <= wrap_c;
    end
  end

`ifdef PWM_PERIOD_CNT_EN
  // Saturating wrap counter, restarted when the upstream counter resyncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= 16'd0;
    end else if (resync_c) begin
      period_cnt <= 16'd0;
    end else if (wrap_pulse && (period_cnt != 16'hFFFF)) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule
